// File: rtl/mem_rd_arbiter.sv
// Two-way arbiter for the shared burst memory read channel (I-cache vs D-cache refill).
// The grant is held from the address handshake through the last response beat.
module mem_rd_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RR_EN      = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req_valid,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  output logic                  i_req_ready,
  output logic                  i_rsp_valid,
  output logic [DATA_WIDTH-1:0] i_rsp_data,
  output logic                  i_rsp_last,
  input  logic                  i_rsp_ready,
  input  logic                  d_req_valid,
  input  logic [ADDR_WIDTH-1:0] d_req_addr,
  output logic                  d_req_ready,
  output logic                  d_rsp_valid,
  output logic [DATA_WIDTH-1:0] d_rsp_data,
  output logic                  d_rsp_last,
  input  logic                  d_rsp_ready,
  output logic                  mem_rd_req_valid,
  output logic [ADDR_WIDTH-1:0] mem_rd_req_addr,
  input  logic                  mem_rd_req_ready,
  input  logic                  mem_rd_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rd_rsp_data,
  input  logic                  mem_rd_rsp_last,
  output logic                  mem_rd_rsp_ready
);

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_REQ  = 3'b010,
    S_RSP  = 3'b100
  } state_e;

  state_e r_state, w_state_nxt;
  logic   r_owner, w_owner_nxt;        // 0 = I-cache, 1 = D-cache
  logic   r_last_owner, w_last_owner_nxt;
  logic   w_pick_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_owner <= w_last_owner_nxt;
    end
  end

  // On a tie, round-robin favours whoever did not own the previous burst.
  always_comb begin
    if (i_req_valid && d_req_valid) begin
      w_pick_d = (RR_EN != 0) ? ~r_last_owner : 1'b1;
    end else begin
      w_pick_d = d_req_valid;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_owner_nxt      = r_owner;
    w_last_owner_nxt = r_last_owner;
    i_req_ready      = 1'b0;
    i_rsp_valid      = 1'b0;
    i_rsp_data       = '0;
    i_rsp_last       = 1'b0;
    d_req_ready      = 1'b0;
    d_rsp_valid      = 1'b0;
    d_rsp_data       = '0;
    d_rsp_last       = 1'b0;
    mem_rd_req_valid = 1'b0;
    mem_rd_req_addr  = '0;
    mem_rd_rsp_ready = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (i_req_valid || d_req_valid) begin
          w_state_nxt = S_REQ;
          w_owner_nxt = w_pick_d;
        end
      end
      S_REQ: begin
        // A dropped owner request parks here without releasing the grant.
        mem_rd_req_valid = r_owner ? d_req_valid : i_req_valid;
        mem_rd_req_addr  = r_owner ? d_req_addr : i_req_addr;
        i_req_ready      = ~r_owner & mem_rd_req_ready;
        d_req_ready      = r_owner & mem_rd_req_ready;
        if (mem_rd_req_valid && mem_rd_req_ready) begin
          w_state_nxt = S_RSP;
        end
      end
      S_RSP: begin
        if (r_owner) begin
          d_rsp_valid      = mem_rd_rsp_valid;
          d_rsp_data       = mem_rd_rsp_data;
          d_rsp_last       = mem_rd_rsp_last;
          mem_rd_rsp_ready = d_rsp_ready;
        end else begin
          i_rsp_valid      = mem_rd_rsp_valid;
          i_rsp_data       = mem_rd_rsp_data;
          i_rsp_last       = mem_rd_rsp_last;
          mem_rd_rsp_ready = i_rsp_ready;
        end
        if (mem_rd_rsp_valid && mem_rd_rsp_ready && mem_rd_rsp_last) begin
          w_state_nxt      = S_IDLE;
          w_last_owner_nxt = r_owner;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule
